tx_lbuf_notify: RTL and testbench
=================================

// Module: tx_lbuf_notify
// PURPOSE
//  Card-to-host end of the lbuf control path. The host hands lbufs to the card by writing BAR registers.
//  This block reports each lbuf_dn back to the host. It issues one posted MWr TLP on the TRN tx interface,
//  2 DW payload, to a host-programmed notification address. It shares TRN tx with the RX DMA writer via a req/gnt arbiter.
// PARAMETERS
//  NOTIFY_LEN_DW   2      payload length field (fixed; exists for header assembly only)
//  BUF_AV_BIT      1      trn_tbuf_av bit that signals posted-credit availability
// PORTS
//  clk               in   1   core clock
//  rst_n             in   1   asynchronous, active-low reset
//  notify_addr       in   64  host notification address (DW aligned); sampled at TLP start
//  notify_addr_vld   in   1   address programmed; no TLP is issued while low
//  lbuf_dn           in   1   1-cycle pulse: lbuf finished
//  lbuf_dn_idx       in   1   0 = lbuf1, 1 = lbuf2
//  lbuf_dn_bytes     in   32  bytes written into the finished lbuf
//  cfg_completer_id  in   16  requester ID for the TLP header
//  notify_req        out  1   request TRN tx ownership
//  notify_gnt        in   1   ownership granted; held by arbiter until notify_req drops
//  trn_td            out  64  TLP data
//  trn_trem_n        out  8   remainder (0x00 = 8 bytes valid, 0x0F = upper 4 bytes valid)
//  trn_tsof_n        out  1   start of frame
//  trn_teof_n        out  1   end of frame
//  trn_tsrc_rdy_n    out  1   beat valid
//  trn_tdst_rdy_n    in   1   core accepts beat
//  trn_tbuf_av       in   4   core buffer availability
//  notify_ovf        out  1   sticky: lbuf_dn arrived for an index already pending
// BEHAVIOUR
//  Reset values
//   - notify_req = 0; all trn_t*_n = 1; trn_td = 0; notify_ovf = 0.
//   - Pending flags clear; seq counter = 0; state IDLE.
//  Capture
//   - lbuf_dn sets pend[idx] and latches bytes[idx] the same cycle.
//   - If pend[idx] is already set: overwrite bytes[idx]; set notify_ovf.
//   - A pulse arriving in the cycle its own pend bit clears (EOF accepted) is a new event. pend stays 1; no ovf.
//  Selection
//   - When both are pending, serve idx 0 first. Then alternate: last_served toggles priority.
//  FSM states
//   - IDLE -> REQ: any pend && notify_addr_vld.
//   - REQ: notify_req = 1. Go to H0 when notify_gnt && trn_tbuf_av[BUF_AV_BIT].
//   - H0 -> H1 -> D -> IDLE.
//   - Each beat holds until the cycle with !trn_tsrc_rdy_n && !trn_tdst_rdy_n.
//   - notify_req drops the cycle after the EOF beat is accepted.
//  TLP header
//   - Use 4DW (fmt 2'b11) when notify_addr[63:32] != 0; otherwise 3DW (fmt 2'b10). Type 5'b00000.
//   - TC 0, attr 0, length 2. Tag = seq[7:0]. Last BE 4'hF, first BE 4'hF.
//  Payload
//   - D0 = {seq[15:0], 15'b0, idx}. D1 = bytes[idx].
//   - Both DWs are byte-reversed into host little-endian order.
//  Beats, 3DW header
//   - {H0,H1}, then {H2,D0}, then {D1,32'h0} with trem_n = 0x0F.
//  Beats, 4DW header
//   - {H0,H1}, then {H2,H3}, then {D0,D1} with trem_n = 0x00.
//  Beat control
//   - trn_tsof_n = 0 on beat 0 only; trn_teof_n = 0 on the last beat only.
//   - trn_tsrc_rdy_n stays 0 continuously from SOF to EOF (no mid-TLP bubbles).
//  Completion and wrap
//   - On EOF accept: clear pend[idx]; seq increments and wraps 16'hFFFF -> 0.
//  Timing
//   - Latency from lbuf_dn to SOF is 3 cycles minimum (idle bus, immediate gnt).
//  Address source
//   - The address is latched on entering H0. Changes to notify_addr mid-TLP do not affect that TLP.
//   - notify_addr_vld low mid-TLP does not abort the TLP.
//  Reset mid-TLP
//   - Outputs return to reset values immediately (asynchronous).
//   - The downstream core is reset by the same rst_n.
// CONFIGURATION
//  Macro: TX_LBUF_NOTIFY_MSI_EN
//   - Adds ports cfg_interrupt_n (out, reset 1) and cfg_interrupt_rdy_n (in).
//   - After each notification EOF is accepted: assert cfg_interrupt_n = 0 until cfg_interrupt_rdy_n = 0.
//   - A second EOF while an interrupt is outstanding is coalesced (no extra interrupt).
//   - Macro undefined: ports absent; no interrupt logic.
// STRUCTURE
//  - Shared include tlp_defs.vh: FMT_3DW_DATA, FMT_4DW_DATA, TYPE_MEM, header field offsets.
//    The RX DMA writer uses the same file.
//  - Sub-module tx_notify_hdr (combinational): takes {addr, len, tag, req_id}.
//    Outputs H0..H3 and the is4dw flag.
//  - FSM, pending flags, seq counter and beat mux stay in this module.
// TESTING
//  1. addr = 0x0000_0000_8000_1000, lbuf_dn idx 0, bytes 0x400, gnt immediate, dst_rdy = 0.
//     -> 3 beats: fmt 2'b10, len 2, D0 = 0x00000000 byte-reversed, D1 = 0x00040000, last trem_n = 0x0F.
//  2. addr = 0x0000_0001_0000_0040, idx 1, bytes 0x10.
//     -> 4DW header, H2 = 0x00000001, H3 = 0x00000040, beat 3 = {D0,D1}, trem_n = 0x00.
//  3. dst_rdy_n toggles 1,0,1,1,0 during the TLP.
//     -> each beat stable while stalled; exactly 3 beats accepted; tsrc_rdy_n never deasserts mid-TLP.
//  4. lbuf_dn idx 0 and idx 1 in back-to-back cycles.
//     -> two TLPs, idx 0 first, seq 0 then 1; notify_ovf stays 0.
//  5. Two lbuf_dn idx 0 before gnt.
//     -> one TLP carrying the second byte count; notify_ovf = 1.
//     notify_addr_vld = 0 -> notify_req never rises.
//  6. trn_tbuf_av[1] = 0 for 10 cycles with gnt high -> no SOF until it returns to 1.
//     rst_n pulsed mid-H1 -> outputs back to reset values in the same cycle.

Source files
------------

// File: rtl/tx_lbuf_notify_pkg.sv
// Shared TLP definitions and notification-engine types for tx_lbuf_notify.
// The fmt/type codes and header field offsets are common with the RX DMA writer.
package tx_lbuf_notify_pkg;

    // TLP format/type codes for memory writes with data
    localparam logic [1:0] FMT_3DW_DATA = 2'b10;
    localparam logic [1:0] FMT_4DW_DATA = 2'b11;
    localparam logic [4:0] TYPE_MEM     = 5'b00000;

    // Header DW0 field offsets
    localparam int HDR_FMT_LSB   = 29;
    localparam int HDR_TYPE_LSB  = 24;
    localparam int HDR_TC_LSB    = 20;
    localparam int HDR_ATTR_LSB  = 12;
    localparam int HDR_LEN_LSB   = 0;

    // Header DW1 field offsets
    localparam int HDR_REQID_LSB = 16;
    localparam int HDR_TAG_LSB   = 8;
    localparam int HDR_LBE_LSB   = 4;
    localparam int HDR_FBE_LSB   = 0;

    // TRN remainder encodings
    localparam logic [7:0] TREM_8B   = 8'h00;
    localparam logic [7:0] TREM_4B   = 8'h0F;
    localparam logic [7:0] TREM_IDLE = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_H0,
        ST_H1,
        ST_D
    } state_t;

    // Payload DWs travel in host little-endian byte order
    function automatic logic [31:0] dw_byte_rev(input logic [31:0] dw);
        return {dw[7:0], dw[15:8], dw[23:16], dw[31:24]};
    endfunction

endpackage

// File: rtl/tx_notify_hdr.sv
// Combinational MWr header builder for the lbuf notification TLP.
// Picks a 4DW header whenever the upper address word is non-zero.
module tx_notify_hdr
    import tx_lbuf_notify_pkg::*;
(
    input  logic [63:2] addr,
    input  logic [9:0]  len,
    input  logic [7:0]  tag,
    input  logic [15:0] req_id,
    output logic [31:0] h0,
    output logic [31:0] h1,
    output logic [31:0] h2,
    output logic [31:0] h3,
    output logic        is4dw
);

    // Assemble the four header DWs from the current address, tag and requester ID
    always_comb begin
        is4dw = |addr[63:32];

        h0 = '0;
        h0[HDR_FMT_LSB  +: 2]  = is4dw ? FMT_4DW_DATA : FMT_3DW_DATA;
        h0[HDR_TYPE_LSB +: 5]  = TYPE_MEM;
        h0[HDR_TC_LSB   +: 3]  = 3'd0;
        h0[HDR_ATTR_LSB +: 2]  = 2'd0;
        h0[HDR_LEN_LSB  +: 10] = len;

        h1 = '0;
        h1[HDR_REQID_LSB +: 16] = req_id;
        h1[HDR_TAG_LSB   +: 8]  = tag;
        h1[HDR_LBE_LSB   +: 4]  = 4'hF;
        h1[HDR_FBE_LSB   +: 4]  = 4'hF;

        if (is4dw) begin
            h2 = addr[63:32];
            h3 = {addr[31:2], 2'b00};
        end else begin
            h2 = {addr[31:2], 2'b00};
            h3 = '0;
        end
    end

endmodule

// File: rtl/tx_lbuf_notify.sv
// lbuf completion notifier: turns each lbuf_dn pulse into a 2-DW posted MWr
// on the shared TRN tx interface, arbitrated against the RX DMA writer.
// Optional MSI signalling is enabled with the TX_LBUF_NOTIFY_MSI_EN macro.
module tx_lbuf_notify
    import tx_lbuf_notify_pkg::*;
#(
    parameter int NOTIFY_LEN_DW = 2,
    parameter int BUF_AV_BIT    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] notify_addr,
    input  logic        notify_addr_vld,
    input  logic        lbuf_dn,
    input  logic        lbuf_dn_idx,
    input  logic [31:0] lbuf_dn_bytes,
    input  logic [15:0] cfg_completer_id,
    output logic        notify_req,
    input  logic        notify_gnt,
    output logic [63:0] trn_td,
    output logic [7:0]  trn_trem_n,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
    input  logic        trn_tdst_rdy_n,
    input  logic [3:0]  trn_tbuf_av,
    output logic        notify_ovf
`ifdef TX_LBUF_NOTIFY_MSI_EN
    ,
    output logic        cfg_interrupt_n,
    input  logic        cfg_interrupt_rdy_n
`endif
);

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  pend_q;
    logic        ovf_q;
    logic [15:0] seq_q;
    logic        last_q;
    logic        cur_idx_q;

    logic [63:2] addr_q;
    logic [31:0] d1_q;
    logic [31:0] bytes_q [2];

    logic [1:0]  set_v;
    logic [1:0]  clr_v;
    logic        sel_idx;
    logic        start;
    logic        beat_acc;
    logic        eof_acc;
    logic [31:0] d0_w;
    logic [31:0] d1_w;
    logic [31:0] h0;
    logic [31:0] h1;
    logic [31:0] h2;
    logic [31:0] h3;
    logic        is4dw;
    logic        spare_unused;

    // DW alignment bits and the non-posted credit bits are not needed here
    assign spare_unused = ^{notify_addr[1:0], trn_tbuf_av};

    assign beat_acc = !trn_tsrc_rdy_n && !trn_tdst_rdy_n;
    assign eof_acc  = (state_q == ST_D) && beat_acc;
    assign start    = (state_q == ST_REQ) && notify_gnt && trn_tbuf_av[BUF_AV_BIT];
    // With both pending, prefer the index not served last (last_q resets to 1 so idx 0 goes first)
    assign sel_idx  = (pend_q[0] && pend_q[1]) ? ~last_q : pend_q[1];

    assign d0_w = dw_byte_rev({seq_q, 15'b0, cur_idx_q});
    assign d1_w = dw_byte_rev(d1_q);

    assign notify_ovf = ovf_q;

    tx_notify_hdr u_hdr (
        .addr   (addr_q),
        .len    (NOTIFY_LEN_DW[9:0]),
        .tag    (seq_q[7:0]),
        .req_id (cfg_completer_id),
        .h0     (h0),
        .h1     (h1),
        .h2     (h2),
        .h3     (h3),
        .is4dw  (is4dw)
    );

    // Per-index set/clear strobes; a set in the clearing cycle wins as a new event
    always_comb begin
        set_v = {lbuf_dn & lbuf_dn_idx, lbuf_dn & ~lbuf_dn_idx};
        clr_v = {eof_acc & cur_idx_q,   eof_acc & ~cur_idx_q};
    end

    // Control state: FSM, pending flags, overflow, sequence and arbitration history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pend_q    <= 2'b00;
            ovf_q     <= 1'b0;
            seq_q     <= 16'd0;
            last_q    <= 1'b1;
            cur_idx_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= (pend_q & ~clr_v) | set_v;
            ovf_q   <= ovf_q | (|(set_v & pend_q & ~clr_v));
            if (start) begin
                cur_idx_q <= sel_idx;
            end
            if (eof_acc) begin
                seq_q  <= seq_q + 16'd1;
                last_q <= cur_idx_q;
            end
        end
    end

    // Payload storage: byte counts per index, plus the TLP snapshot taken on entering H0
    always_ff @(posedge clk) begin
        if (lbuf_dn) begin
            bytes_q[lbuf_dn_idx] <= lbuf_dn_bytes;
        end
        if (start) begin
            addr_q <= notify_addr[63:2];
            // Bypass a count landing in the same cycle so the TLP carries the newest value
            if (lbuf_dn && (lbuf_dn_idx == sel_idx)) begin
                d1_q <= lbuf_dn_bytes;
            end else begin
                d1_q <= bytes_q[sel_idx];
            end
        end
    end

    // Next-state and TRN beat mux; every beat holds until accepted
    always_comb begin
        state_d        = state_q;
        notify_req     = 1'b0;
        trn_td         = '0;
        trn_trem_n     = TREM_IDLE;
        trn_tsof_n     = 1'b1;
        trn_teof_n     = 1'b1;
        trn_tsrc_rdy_n = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if ((|pend_q) && notify_addr_vld) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                notify_req = 1'b1;
                if (start) begin
                    state_d = ST_H0;
                end
            end
            ST_H0: begin
                notify_req     = 1'b1;
                trn_tsrc_rdy_n = 1'b0;
                trn_tsof_n     = 1'b0;
                trn_trem_n     = TREM_8B;
                trn_td         = {h0, h1};
                if (beat_acc) begin
                    state_d = ST_H1;
                end
            end
            ST_H1: begin
                notify_req     = 1'b1;
                trn_tsrc_rdy_n = 1'b0;
                trn_trem_n     = TREM_8B;
                trn_td         = is4dw ? {h2, h3} : {h2, d0_w};
                if (beat_acc) begin
                    state_d = ST_D;
                end
            end
            ST_D: begin
                notify_req     = 1'b1;
                trn_tsrc_rdy_n = 1'b0;
                trn_teof_n     = 1'b0;
                trn_trem_n     = is4dw ? TREM_8B : TREM_4B;
                trn_td         = is4dw ? {d0_w, d1_w} : {d1_w, 32'h0};
                if (beat_acc) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef TX_LBUF_NOTIFY_MSI_EN
    logic irq_q;

    assign cfg_interrupt_n = ~irq_q;

    // One outstanding interrupt; further EOFs before the core acknowledges fold into it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= eof_acc | (irq_q & cfg_interrupt_rdy_n);
        end
    end
`endif

endmodule

// File: tb/tb_tx_lbuf_notify.sv
// Directed bench for tx_lbuf_notify: expected TLP beats are hand-computed constants.
module tb_tx_lbuf_notify;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] notify_addr;
    logic        notify_addr_vld;
    logic        lbuf_dn;
    logic        lbuf_dn_idx;
    logic [31:0] lbuf_dn_bytes;
    logic [15:0] cfg_completer_id;
    logic        notify_req;
    logic        notify_gnt;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tdst_rdy_n;
    logic [3:0]  trn_tbuf_av;
    logic        notify_ovf;
    logic        gnt_en;
`ifdef TX_LBUF_NOTIFY_MSI_EN
    logic        cfg_interrupt_n;
    logic        cfg_interrupt_rdy_n = 1'b0;
`endif

    always #5 clk = ~clk;

    // Arbiter stand-in: grant follows request while enabled
    assign notify_gnt = gnt_en & notify_req;

    tx_lbuf_notify dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .notify_addr      (notify_addr),
        .notify_addr_vld  (notify_addr_vld),
        .lbuf_dn          (lbuf_dn),
        .lbuf_dn_idx      (lbuf_dn_idx),
        .lbuf_dn_bytes    (lbuf_dn_bytes),
        .cfg_completer_id (cfg_completer_id),
        .notify_req       (notify_req),
        .notify_gnt       (notify_gnt),
        .trn_td           (trn_td),
        .trn_trem_n       (trn_trem_n),
        .trn_tsof_n       (trn_tsof_n),
        .trn_teof_n       (trn_teof_n),
        .trn_tsrc_rdy_n   (trn_tsrc_rdy_n),
        .trn_tdst_rdy_n   (trn_tdst_rdy_n),
        .trn_tbuf_av      (trn_tbuf_av),
        .notify_ovf       (notify_ovf)
`ifdef TX_LBUF_NOTIFY_MSI_EN
        ,
        .cfg_interrupt_n     (cfg_interrupt_n),
        .cfg_interrupt_rdy_n (cfg_interrupt_rdy_n)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int dn_cyc   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Accepted-beat capture and protocol observation
    logic [63:0] bq_td   [$];
    logic [7:0]  bq_trem [$];
    logic        bq_sof  [$];
    logic        bq_eof  [$];
    int          bq_cyc  [$];
    int          bubbles   = 0;
    int          stall_chg = 0;
    logic        in_tlp;
    logic        stalled_prev;
    logic [63:0] td_prev;
    logic [7:0]  trem_prev;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_tlp       <= 1'b0;
            stalled_prev <= 1'b0;
        end else begin
            if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
                bq_td.push_back(trn_td);
                bq_trem.push_back(trn_trem_n);
                bq_sof.push_back(trn_tsof_n);
                bq_eof.push_back(trn_teof_n);
                bq_cyc.push_back(cyc);
            end
            if (in_tlp && trn_tsrc_rdy_n) bubbles <= bubbles + 1;
            if (stalled_prev && (trn_td !== td_prev || trn_trem_n !== trem_prev || trn_tsrc_rdy_n))
                stall_chg <= stall_chg + 1;
            if (!trn_tsrc_rdy_n && !trn_tsof_n) in_tlp <= 1'b1;
            if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n && !trn_teof_n) in_tlp <= 1'b0;
            stalled_prev <= !trn_tsrc_rdy_n && trn_tdst_rdy_n;
            td_prev      <= trn_td;
            trem_prev    <= trn_trem_n;
        end
    end

    task automatic clear_q();
        bq_td.delete();
        bq_trem.delete();
        bq_sof.delete();
        bq_eof.delete();
        bq_cyc.delete();
    endtask

    task automatic pulse(input logic idx, input logic [31:0] b);
        @(negedge clk);
        lbuf_dn       = 1'b1;
        lbuf_dn_idx   = idx;
        lbuf_dn_bytes = b;
        dn_cyc        = cyc;
        @(negedge clk);
        lbuf_dn = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget, input string tag);
        int k = 0;
        while (bq_td.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 64'(bq_td.size()), 64'(n));
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req"},  64'(notify_req),     64'd0);
        check({pfx, "_src"},  64'(trn_tsrc_rdy_n), 64'd1);
        check({pfx, "_sof"},  64'(trn_tsof_n),     64'd1);
        check({pfx, "_eof"},  64'(trn_teof_n),     64'd1);
        check({pfx, "_td"},   trn_td,              64'd0);
        check({pfx, "_trem"}, 64'(trn_trem_n),     64'hFF);
        check({pfx, "_ovf"},  64'(notify_ovf),     64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int req_seen;
        int sof_seen;
        int k;
        int pat [5] = '{1, 0, 1, 1, 0};

        rst_n            = 1'b0;
        lbuf_dn          = 1'b0;
        lbuf_dn_idx      = 1'b0;
        lbuf_dn_bytes    = '0;
        notify_addr      = 64'h0000_0000_8000_1000;
        notify_addr_vld  = 1'b1;
        cfg_completer_id = 16'h0100;
        gnt_en           = 1'b1;
        trn_tdst_rdy_n   = 1'b0;
        trn_tbuf_av      = 4'hF;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: 3DW header, idx 0, 0x400 bytes
        clear_q();
        pulse(1'b0, 32'h400);
        wait_beats(3, 30, "t1_beats");
        check("t1_b0",   bq_td[0], 64'h40000002_010000FF);
        check("t1_b1",   bq_td[1], 64'h80001000_00000000);
        check("t1_b2",   bq_td[2], 64'h00040000_00000000);
        check("t1_trem0", 64'(bq_trem[0]), 64'h00);
        check("t1_trem2", 64'(bq_trem[2]), 64'h0F);
        check("t1_sof",  64'({bq_sof[0], bq_sof[1], bq_sof[2]}), 64'b011);
        check("t1_eof",  64'({bq_eof[0], bq_eof[1], bq_eof[2]}), 64'b110);
        check("t1_lat",  64'(bq_cyc[0] - dn_cyc), 64'd3);
        check("t1_req_drop", 64'(notify_req), 64'd0);
        check("t1_ovf",  64'(notify_ovf), 64'd0);

        // 2: 4DW header, idx 1, 0x10 bytes, seq 1
        clear_q();
        notify_addr = 64'h0000_0001_0000_0040;
        pulse(1'b1, 32'h10);
        wait_beats(3, 30, "t2_beats");
        check("t2_b0",    bq_td[0], 64'h60000002_010001FF);
        check("t2_b1",    bq_td[1], 64'h00000001_00000040);
        check("t2_b2",    bq_td[2], 64'h01000100_10000000);
        check("t2_trem2", 64'(bq_trem[2]), 64'h00);

        // 3: destination stalls mid-TLP, idx 1, seq 2
        clear_q();
        notify_addr    = 64'h0000_0000_8000_1000;
        trn_tdst_rdy_n = 1'b1;
        pulse(1'b1, 32'h20);
        k = 0;
        while (trn_tsrc_rdy_n && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t3_sof_seen", 64'(trn_tsrc_rdy_n), 64'd0);
        foreach (pat[i]) begin
            trn_tdst_rdy_n = pat[i][0];
            @(negedge clk);
        end
        trn_tdst_rdy_n = 1'b0;
        wait_beats(3, 20, "t3_beats");
        repeat (3) @(negedge clk);
        check("t3_count",   64'(bq_td.size()), 64'd3);
        check("t3_bubbles", 64'(bubbles), 64'd0);
        check("t3_stable",  64'(stall_chg), 64'd0);
        check("t3_b0",      bq_td[0], 64'h40000002_010002FF);
        check("t3_b1",      bq_td[1], 64'h80001000_01000200);
        check("t3_b2",      bq_td[2], 64'h20000000_00000000);

        // 4: back-to-back idx 0 then idx 1
        clear_q();
        @(negedge clk);
        lbuf_dn = 1'b1; lbuf_dn_idx = 1'b0; lbuf_dn_bytes = 32'h100;
        @(negedge clk);
        lbuf_dn_idx = 1'b1; lbuf_dn_bytes = 32'h200;
        @(negedge clk);
        lbuf_dn = 1'b0;
        wait_beats(6, 60, "t4_beats");
        check("t4_b0",  bq_td[0], 64'h40000002_010003FF);
        check("t4_b1",  bq_td[1], 64'h80001000_00000300);
        check("t4_b2",  bq_td[2], 64'h00010000_00000000);
        check("t4_b3",  bq_td[3], 64'h40000002_010004FF);
        check("t4_b4",  bq_td[4], 64'h80001000_01000400);
        check("t4_b5",  bq_td[5], 64'h00020000_00000000);
        check("t4_ovf", 64'(notify_ovf), 64'd0);

        // 5: two idx 0 events before grant -> one TLP with the latest count
        clear_q();
        gnt_en = 1'b0;
        @(negedge clk);
        lbuf_dn = 1'b1; lbuf_dn_idx = 1'b0; lbuf_dn_bytes = 32'h111;
        @(negedge clk);
        lbuf_dn_bytes = 32'h222;
        @(negedge clk);
        lbuf_dn = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_req_wait", 64'(notify_req), 64'd1);
        check("t5_ovf",      64'(notify_ovf), 64'd1);
        check("t5_no_beat",  64'(bq_td.size()), 64'd0);
        gnt_en = 1'b1;
        wait_beats(3, 30, "t5_beats");
        repeat (10) @(negedge clk);
        check("t5_count", 64'(bq_td.size()), 64'd3);
        check("t5_b0",    bq_td[0], 64'h40000002_010005FF);
        check("t5_b1",    bq_td[1], 64'h80001000_00000500);
        check("t5_b2",    bq_td[2], 64'h22020000_00000000);

        // 5b: address not valid -> no request until it is
        clear_q();
        notify_addr_vld = 1'b0;
        pulse(1'b1, 32'h5);
        req_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (notify_req) req_seen++;
        end
        check("t5b_no_req", 64'(req_seen), 64'd0);
        notify_addr_vld = 1'b1;
        wait_beats(3, 30, "t5b_beats");
        check("t5b_b1", bq_td[1], 64'h80001000_01000600);
        check("t5b_b2", bq_td[2], 64'h05000000_00000000);

        // 6: no posted credit -> no SOF; then reset in the middle beat
        clear_q();
        trn_tbuf_av = 4'b1101;
        pulse(1'b0, 32'h40);
        sof_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (!trn_tsrc_rdy_n) sof_seen++;
        end
        check("t6_no_sof", 64'(sof_seen), 64'd0);
        check("t6_req",    64'(notify_req), 64'd1);
        trn_tbuf_av = 4'hF;
        k = 0;
        while (!(!trn_tsrc_rdy_n && trn_tsof_n && trn_teof_n) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t6_mid_td", 64'(trn_td[63:32]), 64'h80001000);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        repeat (8) @(negedge clk);
        check("t6_idle_after_rst", 64'(bq_td.size()), 64'd0);
        pulse(1'b1, 32'h8);
        wait_beats(3, 30, "t6_beats");
        check("t6_b0", bq_td[0], 64'h40000002_010000FF);
        check("t6_b1", bq_td[1], 64'h80001000_01000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
